ram_arbiter: RTL

Two-requester arbiter and sequencer for the 8-entry × 8-bit single-port RAM. It accepts read/write requests from two independent masters and grants them round-robin. It drives the RAM's `adr`, `data_in` and `write_signal` inputs, captures `data_out` after the RAM read latency, and returns read data with a one-cycle acknowledge pulse. It sits directly in front of the RAM; the RAM itself is unchanged.

---
 rtl/ram_arb_pkg.sv | 19 +
 rtl/rr_arbiter2.sv | 17 +
 rtl/ram_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the two-requester RAM arbiter.
package ram_arb_pkg;

   localparam int AW_DEF = 3;
   localparam int DW_DEF = 8;
   localparam int CNT_W  = 2;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } state_e;

   function automatic logic [1:0] id_to_onehot(input logic id);
      return id ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick: a lone requester always wins,
// a tie is broken by the pointer.
module rr_arbiter2
   import ram_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       ptr,
   output logic [1:0] grant,
   output logic       grant_id
);

   always_comb begin
      grant_id = (req == 2'b11) ? ptr : req[1];
      grant    = (req == 2'b00) ? 2'b00 : id_to_onehot(grant_id);
   end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter and sequencer in front of a single-port RAM: grants
// one requester at a time, issues the access and returns read data with ack.
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int AW     = AW_DEF,
   parameter int DW     = DW_DEF,
   parameter int RD_LAT = 1
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic [1:0]    req,
   input  logic [1:0]    we,
   input  logic [AW-1:0] adr0,
   input  logic [AW-1:0] adr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic [1:0]    ack,
   output logic [DW-1:0] rdata,
   output logic          busy,
   output logic [AW-1:0] ram_adr,
   output logic [DW-1:0] ram_data_in,
   output logic          ram_write,
   input  logic [DW-1:0] ram_data_out
);

   localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RD_LAT - 1);

   state_e           state_q, state_d;
   logic             ptr_q, ptr_d;
   logic             id_q, id_d;
   logic             we_q, we_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       ack_q, ack_d;
   logic [DW-1:0]    rdata_q, rdata_d;
   logic             busy_q, busy_d;
   logic [AW-1:0]    ram_adr_q, ram_adr_d;
   logic [DW-1:0]    ram_data_in_q, ram_data_in_d;
   logic             ram_write_q, ram_write_d;

   logic [1:0]       grant;
   logic             grant_id;

   rr_arbiter2 u_rr (
      .req      (req),
      .ptr      (ptr_q),
      .grant    (grant),
      .grant_id (grant_id)
   );

   // The RAM address/data output registers double as the request latch.
   always_comb begin
      // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
      state_d       = state_q;
      ptr_d         = ptr_q;
      id_d          = id_q;
      we_d          = we_q;
      cnt_d         = cnt_q;
      rdata_d       = rdata_q;
      ram_adr_d     = ram_adr_q;
      ram_data_in_d = ram_data_in_q;
      ack_d         = 2'b00;
      ram_write_d   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (|req) begin
               id_d          = grant_id;
               we_d          = |(grant & we);
               ram_adr_d     = grant[1] ? adr1 : adr0;
               ram_data_in_d = grant[1] ? wdata1 : wdata0;
               ram_write_d   = |(grant & we);
               state_d       = ISSUE;
            end
         end
         ISSUE: begin
            if (we_q) begin
               ack_d   = id_to_onehot(id_q);
               state_d = DONE;
            end else begin
               cnt_d   = LAT_LOAD;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               rdata_d = ram_data_out;
               ack_d   = id_to_onehot(id_q);
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         DONE: begin
            ptr_d   = ~id_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         ptr_q         <= 1'b0;
         id_q          <= 1'b0;
         we_q          <= 1'b0;
         cnt_q         <= '0;
         ack_q         <= 2'b00;
         rdata_q       <= '0;
         busy_q        <= 1'b0;
         ram_adr_q     <= '0;
         ram_data_in_q <= '0;
         ram_write_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking here so every register samples pre-edge values.
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         id_q          <= id_d;
         we_q          <= we_d;
         cnt_q         <= cnt_d;
         ack_q         <= ack_d;
         rdata_q       <= rdata_d;
         busy_q        <= busy_d;
         ram_adr_q     <= ram_adr_d;
         ram_data_in_q <= ram_data_in_d;
         ram_write_q   <= ram_write_d;
      end
   end

   assign ack         = ack_q;
   assign rdata       = rdata_q;
   assign busy        = busy_q;
   assign ram_adr     = ram_adr_q;
   assign ram_data_in = ram_data_in_q;
   assign ram_write   = ram_write_q;

endmodule
